// File: rtl/program_launcher.sv
// Host-side sequencer that starts up to four programs on the processor one after another,
// times each run from Start release to Ack, and stops the sequence early if a program hangs.
module program_launcher #(
    parameter int unsigned          START_CYCLES = 2,
    parameter int unsigned          CNT_W        = 16,
    parameter logic [CNT_W-1:0]     TIMEOUT      = 16'hFFFF
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Go_i,
    input  logic [1:0]       NumProgs_i,
    input  logic             DutAck_i,
    output logic             DutStart_o,
    output logic [1:0]       ProgIdx_o,
    output logic             Busy_o,
    output logic             CountValid_o,
    output logic [CNT_W-1:0] CycleCount_o,
    output logic             TimedOut_o,
    output logic             Done_o
);

    // state    | meaning
    // S_IDLE   | waiting for Go after reset
    // S_START  | DutStart held high; Ack ignored (stale halt from the previous program)
    // S_RUN    | counting cycles until Ack or TIMEOUT
    // S_REPORT | one-cycle CountValid strobe for the current program
    // S_DONE   | sequence finished; Go restarts it
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RUN, S_REPORT, S_DONE
    } state_t;

    localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SW-1:0] START_LOAD = SW'(START_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       num_q, num_d;
    logic [1:0]       idx_q, idx_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             to_q, to_d;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            scnt_q  <= '0;
            rcnt_q  <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            scnt_q  <= scnt_d;
            rcnt_q  <= rcnt_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        rcnt_d  = rcnt_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Go_i) begin
                    num_d   = NumProgs_i;
                    idx_d   = '0;
                    scnt_d  = START_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (scnt_q == '0) begin
                    rcnt_d  = '0;
                    state_d = S_RUN;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            S_RUN: begin
                // Ack wins over the timeout so an Ack on the last allowed cycle still counts
                if (DutAck_i) begin
                    cyc_d   = rcnt_q;
                    to_d    = 1'b0;
                    state_d = S_REPORT;
                end else if (rcnt_q == TIMEOUT) begin
                    cyc_d   = TIMEOUT;
                    to_d    = 1'b1;
                    state_d = S_REPORT;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (to_q || (idx_q == num_q)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    scnt_d  = START_LOAD;
                    state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign DutStart_o   = (state_q == S_START);
    assign Busy_o       = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_REPORT);
    assign CountValid_o = (state_q == S_REPORT);
    assign Done_o       = (state_q == S_DONE);
    assign ProgIdx_o    = idx_q;
    assign CycleCount_o = cyc_q;
    assign TimedOut_o   = to_q;

endmodule
